// File: rtl/fcvt_int2fp_pipe_if.sv
// Request/response channel of the integer-to-single converter.
// The master side issues operations and consumes results.
interface fcvt_int2fp_pipe_if #(
  parameter int TAG_W = 6
);
  logic             in_valid;
  logic             in_ready;
  logic             in_signed;
  logic [31:0]      in_data;
  logic [2:0]       in_rm;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_nx;

  modport master (
    output in_valid, in_signed, in_data, in_rm, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_nx
  );

  modport slave (
    input  in_valid, in_signed, in_data, in_rm, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_nx
  );
endinterface

// File: rtl/fcvt_int2fp_pipe.sv
// Three-stage FCVT.S.W / FCVT.S.WU pipeline: prepare, normalize, round and pack.
// Valid/ready on both sides with bubble collapsing and a synchronous flush.
module fcvt_int2fp_pipe #(
  parameter int TAG_W = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  fcvt_int2fp_pipe_if.slave bus
);

  logic             v1_q, v2_q, v3_q;
  logic             sign1_q, sign2_q;
  logic [31:0]      mag1_q;
  logic [2:0]       rm1_q, rm2_q;
  logic [TAG_W-1:0] tag1_q, tag2_q, tag3_q;
  logic [30:0]      norm2_q;
  logic [7:0]       exp2_q;
  logic             zero2_q;
  logic [31:0]      data3_q;
  logic             nx3_q;

  logic             adv3, ld2, ld1;
  logic             sign1_d;
  logic [31:0]      mag1_d;
  logic [4:0]       lz2_d;
  logic [31:0]      shift2_d;
  logic [30:0]      norm2_d;
  logic [7:0]       exp2_d;
  logic             zero2_d;
  logic [22:0]      m3;
  logic             g3, s3, nx3, up3;
  logic [23:0]      mInc3;
  logic [7:0]       expR3;
  logic [31:0]      data3_d;
  logic             nx3_d;

  // A stage loads when it is empty or its contents move on in the same cycle.
  assign adv3         = !v3_q || bus.out_ready;
  assign ld2          = !v2_q || adv3;
  assign ld1          = !v1_q || ld2;
  assign bus.in_ready = ld1;

  assign sign1_d = bus.in_signed & bus.in_data[31];
  assign mag1_d  = sign1_d ? (~bus.in_data + 32'd1) : bus.in_data;

  // Normalization: the shifted top bit is set exactly when the magnitude is nonzero.
  always_comb begin
    lz2_d = 5'd31;
    for (int i = 0; i < 32; i++) begin
      if (mag1_q[i]) lz2_d = 5'(31 - i);
    end
    shift2_d = mag1_q << lz2_d;
    norm2_d  = shift2_d[30:0];
    zero2_d  = !shift2_d[31];
    exp2_d   = 8'd158 - {3'b000, lz2_d};
  end

  always_comb begin
    m3  = norm2_q[30:8];
    g3  = norm2_q[7];
    s3  = |norm2_q[6:0];
    nx3 = g3 | s3;
    case (rm2_q)
      3'd1:    up3 = 1'b0;
      3'd2:    up3 = sign2_q & nx3;
      3'd3:    up3 = ~sign2_q & nx3;
      3'd4:    up3 = g3;
      default: up3 = g3 & (s3 | m3[0]);
    endcase
    // A mantissa carry-out leaves the fraction at zero and bumps the exponent.
    mInc3   = {1'b0, m3} + {23'd0, up3};
    expR3   = exp2_q + {7'd0, mInc3[23]};
    data3_d = zero2_q ? 32'd0 : {sign2_q, expR3, mInc3[22:0]};
    nx3_d   = zero2_q ? 1'b0 : nx3;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q    <= 1'b0;
      sign1_q <= 1'b0;
      mag1_q  <= '0;
      rm1_q   <= '0;
      tag1_q  <= '0;
    end else begin
      if (flush)    v1_q <= 1'b0;
      else if (ld1) v1_q <= bus.in_valid;
      if (ld1 && bus.in_valid) begin
        sign1_q <= sign1_d;
        mag1_q  <= mag1_d;
        rm1_q   <= bus.in_rm;
        tag1_q  <= bus.in_tag;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_q    <= 1'b0;
      sign2_q <= 1'b0;
      rm2_q   <= '0;
      tag2_q  <= '0;
      norm2_q <= '0;
      exp2_q  <= '0;
      zero2_q <= 1'b0;
    end else begin
      if (flush)    v2_q <= 1'b0;
      else if (ld2) v2_q <= v1_q;
      if (ld2 && v1_q) begin
        sign2_q <= sign1_q;
        rm2_q   <= rm1_q;
        tag2_q  <= tag1_q;
        norm2_q <= norm2_d;
        exp2_q  <= exp2_d;
        zero2_q <= zero2_d;
      end
    end
  end

  // The output register only changes on advance, so a stalled result holds still.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3_q    <= 1'b0;
      data3_q <= '0;
      tag3_q  <= '0;
      nx3_q   <= 1'b0;
    end else begin
      if (flush)     v3_q <= 1'b0;
      else if (adv3) v3_q <= v2_q;
      if (adv3 && v2_q) begin
        data3_q <= data3_d;
        tag3_q  <= tag2_q;
        nx3_q   <= nx3_d;
      end
    end
  end

  assign bus.out_valid = v3_q;
  assign bus.out_data  = data3_q;
  assign bus.out_tag   = tag3_q;
  assign bus.out_nx    = nx3_q;

endmodule

// File: doc/fcvt_int2fp_pipe.md
# fcvt_int2fp_pipe

Three-stage pipelined integer-to-single-precision converter for FCVT.S.W / FCVT.S.WU. It sits between the FP reservation station and the FP writeback arbiter. It handles signed and unsigned operands and applies full IEEE-754 rounding under the five RISC-V rounding modes. The result is tagged, with a precise inexact (NX) flag. Valid/ready flow control runs on both sides, with stall propagation and a pipeline flush.

## Interface

Parameters:
- TAG_W, 6, width of the destination/ROB tag carried alongside each operation

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous kill of all in-flight operations (branch mispredict)
- in_valid  in  1  request present
- in_ready  out  1  block can accept this cycle
- in_signed  in  1  1 = FCVT.S.W (two's complement), 0 = FCVT.S.WU
- in_data  in  32  integer operand
- in_rm  in  3  static rounding mode, already resolved: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM
- in_tag  in  TAG_W  tag passed through unchanged
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts this cycle
- out_data  out  32  IEEE-754 single result
- out_tag  out  TAG_W  tag of the result
- out_nx  out  1  inexact flag for fflags

## Operation

- **Stage 1, prepare**
  - Registers sign, magnitude, rm and tag.
  - sign = in_signed & in_data[31].
  - mag = sign ? (~in_data + 1) : in_data.
  - The 32-bit magnitude of 0x80000000 is 0x80000000.
- **Stage 2, normalize**
  - lz = leading-zero count of mag, 0..31.
  - norm = mag << lz.
  - exp = 158 − lz, 8 bits.
  - zero = (mag == 0).
- **Stage 3, round and pack**
  - Mantissa candidate: m = norm[30:8].
  - Guard bit: g = norm[7].
  - Sticky bit: s = |norm[6:0].
  - Inexact: nx = g | s.
- **Round-up condition by mode**
  - RNE: g & (s | m[0]).
  - RTZ: 0.
  - RDN: sign & nx.
  - RUP: ~sign & nx.
  - RMM: g.
  - rm values 5–7 are treated as RNE.
- **Mantissa carry:** if m = 0x7FFFFF and rounds up, m becomes 0 and exp increments. No overflow is possible; the maximum result is 2^32, exp 159.
- **Pack:** out_data = {sign, exp, m}.
- **Zero operand:** out_data = 0x00000000 (+0 under every mode), nx = 0.
- **Flow control**
  - Each stage holds a valid bit.
  - Stage k loads when it is empty or when its contents move to stage k+1 in the same cycle.
  - The stage 3 output register advances when out_ready = 1 or out_valid = 0.
  - in_ready = !v1 | (stage-1 contents advancing this cycle). This is a full-throughput, bubble-collapsing pipeline.
- **Output stability:** while out_valid = 1 and out_ready = 0, out_data, out_tag and out_nx hold stable.
- **Flush**
  - flush = 1 clears v1, v2 and v3 at the clock edge.
  - A request presented with in_valid in the flush cycle is discarded, even though in_ready may be 1.
  - out_valid is 0 in the following cycle.

## Timing

- **Reset:** while rst is asserted, and after it, all valid bits are 0. This gives out_valid = 0, out_data = 0, out_tag = 0, out_nx = 0 and in_ready = 1.
- **Reset during operation:** in-flight operations are lost and no partial result is emitted.
- **Latency:** a request accepted at edge N appears with out_valid = 1 after edge N+2, i.e. in cycle N+3 relative to the accept cycle N. This holds with no backpressure.
- **Throughput:** one result per cycle with out_ready held at 1.
- **Backpressure:**
  - out_ready = 0 with all three stages full gives in_ready = 0 in the same cycle (combinational path from out_ready).
  - If stages 1–2 have bubbles, in_ready stays 1 until they fill.
- **Simultaneous events:** flush together with out_ready = 1 and out_valid = 1 still counts as a completed handshake for the stage-3 result. The consumer is responsible for discarding it by tag.

## Test plan

- **Unsigned max:** unsigned 0xFFFFFFFF, RNE → 0x4F800000, nx = 1. Under RTZ → 0x4F7FFFFF, nx = 1.
- **Signed edge values, RNE:**
  - 0xFFFFFFFF → 0xBF800000, nx = 0.
  - 0x80000000 → 0xCF000000, nx = 0.
  - 0x00000000 → 0x00000000, nx = 0.
- **Ties and directed rounding:**
  - Unsigned 0x01000001, RNE → 0x4B800000, nx = 1 (tie to even).
  - Unsigned 0x01000003, RNE → 0x4B800002.
  - 0x01000001, RUP → 0x4B800001.
  - 0x01000001, RMM → 0x4B800001.
  - Signed 0xFEFFFFFF (−0x01000001), RDN → 0xCB800001, RUP → 0xCB800000.
- **Streaming:** 8 back-to-back requests with tags 0..7 and out_ready = 1 → first result 3 cycles after the first accept, then one per cycle. Tags and values come out in order.
- **Backpressure:** hold out_ready = 0 for 5 cycles mid-stream. Required response:
  - in_ready drops once 3 operations are held.
  - The output stays stable.
  - No loss or duplication on release.
- **Flush and reset:** assert flush with 3 operations in flight → out_valid = 0 the next cycle, and the next new request emerges after 3 cycles. Assert rst mid-stream → all outputs 0 and in_ready = 1 immediately.
